divisable_by_six_transmitter: RTL and testbench

Transmit side of the two-wire X/Y unit-count interface consumed by the divisible-by-six one-hot checker. Accepts a unit count over a valid/ready handshake and serialises it onto `x_out`/`y_out` at up to 2 units per cycle. It keeps a one-hot mod-6 residue of all units sent since reset, bit-identical to the receiver's state. Sits in front of the checker in lab benches and as a stimulus source for the workshop FSM labs.

---
 rtl/div6_pkg.sv | 48 ++++
 rtl/mod6_residue_tracker.sv | 25 ++
 rtl/divisable_by_six_transmitter.sv | 133 +++++++++++++
 tb/tb_divisable_by_six_transmitter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/div6_pkg.sv
// Shared types, constants and residue helpers for the divisible-by-six X/Y transmitter.
package div6_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    PAD  = 2'd2
  } state_e;

  // One-hot residue encodings: bit k set means running total mod 6 == k.
  localparam logic [5:0] RES_ZERO  = 6'b000001;
  localparam logic [5:0] RES_ONE   = 6'b000010;
  localparam logic [5:0] RES_TWO   = 6'b000100;
  localparam logic [5:0] RES_THREE = 6'b001000;
  localparam logic [5:0] RES_FOUR  = 6'b010000;
  localparam logic [5:0] RES_FIVE  = 6'b100000;

  // Unit patterns as {x, y}; y is only ever set together with x.
  localparam logic [1:0] U0 = 2'b00;
  localparam logic [1:0] U1 = 2'b10;
  localparam logic [1:0] U2 = 2'b11;

  // Rotate the one-hot residue left by 0, 1 or 2 units, wrapping 5 -> 0.
  function automatic logic [5:0] res_rotate(input logic [5:0] res, input logic [1:0] units);
    logic [5:0] v;
    unique case (units)
      2'd1:    v = {res[4:0], res[5]};
      2'd2:    v = {res[3:0], res[5:4]};
      default: v = res;
    endcase
    return v;
  endfunction

  // Units needed to bring the residue back to zero: (6 - k) mod 6.
  function automatic logic [2:0] res_pad_units(input logic [5:0] res);
    logic [2:0] v;
    unique case (res)
      RES_ONE:   v = 3'd5;
      RES_TWO:   v = 3'd4;
      RES_THREE: v = 3'd3;
      RES_FOUR:  v = 3'd2;
      RES_FIVE:  v = 3'd1;
      default:   v = 3'd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/mod6_residue_tracker.sv
// One-hot mod-6 running total of units seen on the X/Y lanes; mirrors the receiver state.
module mod6_residue_tracker
  import div6_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       x,
  input  logic       y,
  output logic [5:0] residue
);

  logic [5:0] r_residue;

  // Advance the residue by the number of units present on this edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_residue <= RES_ZERO;
    end else begin
      r_residue <= res_rotate(r_residue, {1'b0, x} + {1'b0, y});
    end
  end

  assign residue = r_residue;

endmodule

// File: rtl/divisable_by_six_transmitter.sv
// Serialises a unit count onto the X/Y lanes at up to two units per cycle.
// Optional DIV6_PAD_TO_SIX_EN adds a PAD state that tops every request up to a multiple of six.
module divisable_by_six_transmitter
  import div6_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CNT_W-1:0] in_count,
  output logic             x_out,
  output logic             y_out,
  output logic             busy,
  output logic             done,
  output logic [5:0]       residue,
  output logic             aligned
);

  state_e           r_state;
  logic [CNT_W-1:0] r_rem;
  logic             r_x;
  logic             r_y;
  logic             r_done;
  logic             r_busy;
  logic             r_in_ready;
  logic [5:0]       w_residue;

`ifdef DIV6_PAD_TO_SIX_EN
  logic [5:0]       w_res_next;
  logic [CNT_W-1:0] w_pad;

  // Residue as it will stand once the units on the lanes this cycle are counted.
  assign w_res_next = res_rotate(w_residue, {1'b0, r_x} + {1'b0, r_y});
  assign w_pad      = CNT_W'(res_pad_units(w_res_next));
`endif

  // Pattern for the next cycle: two units while at least two remain, otherwise one.
  function automatic logic [1:0] unit_pat(input logic [CNT_W-1:0] n);
    return (n >= CNT_W'(2)) ? U2 : U1;
  endfunction

  // Units left after emitting one cycle's worth from n (n > 0, so no underflow).
  function automatic logic [CNT_W-1:0] unit_take(input logic [CNT_W-1:0] n);
    return (n >= CNT_W'(2)) ? n - CNT_W'(2) : n - CNT_W'(1);
  endfunction

  // Request FSM; r_rem holds the units still owed after the pair currently on the lanes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_rem      <= '0;
      {r_x, r_y} <= U0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_in_ready <= 1'b1;
    end else begin
      r_done     <= 1'b0;
      {r_x, r_y} <= U0;
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            if (in_count == '0) begin
              r_done <= 1'b1;
            end else begin
              {r_x, r_y} <= unit_pat(in_count);
              r_rem      <= unit_take(in_count);
              r_state    <= SEND;
              r_busy     <= 1'b1;
              r_in_ready <= 1'b0;
            end
          end
        end
        SEND: begin
          if (r_rem != '0) begin
            {r_x, r_y} <= unit_pat(r_rem);
            r_rem      <= unit_take(r_rem);
          end
`ifdef DIV6_PAD_TO_SIX_EN
          else if (w_pad != '0) begin
            {r_x, r_y} <= unit_pat(w_pad);
            r_rem      <= unit_take(w_pad);
            r_state    <= PAD;
          end
`endif
          else begin
            r_state    <= IDLE;
            r_done     <= 1'b1;
            r_busy     <= 1'b0;
            r_in_ready <= 1'b1;
          end
        end
`ifdef DIV6_PAD_TO_SIX_EN
        PAD: begin
          if (r_rem != '0) begin
            {r_x, r_y} <= unit_pat(r_rem);
            r_rem      <= unit_take(r_rem);
          end else begin
            r_state    <= IDLE;
            r_done     <= 1'b1;
            r_busy     <= 1'b0;
            r_in_ready <= 1'b1;
          end
        end
`endif
        default: begin
          r_state    <= IDLE;
          r_rem      <= '0;
          r_busy     <= 1'b0;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  mod6_residue_tracker u_residue (
    .clk     (clk),
    .reset   (reset),
    .x       (r_x),
    .y       (r_y),
    .residue (w_residue)
  );

  assign x_out    = r_x;
  assign y_out    = r_y;
  assign done     = r_done;
  assign busy     = r_busy;
  assign in_ready = r_in_ready;
  assign residue  = w_residue;
  assign aligned  = w_residue[0];

endmodule

// File: tb/tb_divisable_by_six_transmitter.sv
// Directed scoreboard bench for divisable_by_six_transmitter (either DIV6_PAD_TO_SIX_EN build).
`timescale 1ns/1ps
module tb_divisable_by_six_transmitter;

  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [CNT_W-1:0] in_count;
  logic             x_out;
  logic             y_out;
  logic             busy;
  logic             done;
  logic [5:0]       residue;
  logic             aligned;
  logic [5:0]       ref_res;

  typedef struct packed {
    logic       x;
    logic       y;
    logic       dn;
    logic [5:0] res;
  } exp_t;

  exp_t sb[$];
  int   tot;
  int   n_vec;
  int   n_err;

  always #5 clk = ~clk;

  divisable_by_six_transmitter #(.CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_count (in_count),
    .x_out    (x_out),
    .y_out    (y_out),
    .busy     (busy),
    .done     (done),
    .residue  (residue),
    .aligned  (aligned)
  );

  // Receiver reference fed from the DUT lanes.
  mod6_residue_tracker u_ref (
    .clk     (clk),
    .reset   (reset),
    .x       (x_out),
    .y       (y_out),
    .residue (ref_res)
  );

  function automatic logic [5:0] oh(input int t);
    return 6'(1 << (t % 6));
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected per-cycle lane activity for n units, two then one.
  task automatic push_units(input int n);
    int left;
    int u;
    left = n;
    while (left > 0) begin
      u = (left >= 2) ? 2 : 1;
      sb.push_back('{x: 1'b1, y: (u == 2), dn: 1'b0, res: oh(tot)});
      tot  += u;
      left -= u;
    end
  endtask

  task automatic issue(input int cnt);
    in_valid = 1'b1;
    in_count = CNT_W'(cnt);
    push_units(cnt);
`ifdef DIV6_PAD_TO_SIX_EN
    if ((tot % 6) != 0) push_units(6 - (tot % 6));
`endif
    sb.push_back('{x: 1'b0, y: 1'b0, dn: 1'b1, res: oh(tot)});
  endtask

  task automatic check_cycle(output bit fin);
    exp_t e;
    e = sb.pop_front();
    chk("x_out",   8'(x_out),      8'(e.x));
    chk("y_out",   8'(y_out),      8'(e.y));
    chk("done",    8'(done),       8'(e.dn));
    chk("busy",    8'(busy),       8'(!e.dn));
    chk("residue", 8'(residue),    8'(e.res));
    chk("aligned", 8'(aligned),    8'(ref_res[0]));
    if (e.dn) chk("in_ready_done", 8'(in_ready), 8'(1));
    fin = e.dn;
  endtask

  // Compare cycles until the done record; optionally chain a request in the done cycle.
  task automatic drain(input int next_cnt);
    bit fin;
    int guard;
    fin   = 1'b0;
    guard = 0;
    while (!fin) begin
      @(negedge clk);
      in_valid = 1'b0;
      guard++;
      n_vec++;
      assert (sb.size() != 0 && guard <= 400) else begin
        n_err++;
        $error("FAIL drain_bound: observed guard %0d queue %0d expected a done record", guard, sb.size());
        break;
      end
      check_cycle(fin);
      if (fin && next_cnt >= 0) issue(next_cnt);
    end
  endtask

  initial begin
    bit fin;
    n_vec    = 0;
    n_err    = 0;
    tot      = 0;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_count = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", 8'(in_ready), 8'(1));
    chk("rst_busy",     8'(busy),     8'(0));
    chk("rst_done",     8'(done),     8'(0));
    chk("rst_xy",       8'({x_out, y_out}), 8'(0));
    chk("rst_residue",  8'(residue),  8'(6'b000001));
    reset = 1'b0;
    @(negedge clk);
    chk("idle_residue", 8'(residue),  8'(6'b000001));

    // Count 5 from reset.
    issue(5);
    drain(-1);
`ifdef DIV6_PAD_TO_SIX_EN
    chk("c5_residue", 8'(residue), 8'(6'b000001));
    chk("c5_aligned", 8'(aligned), 8'(1));
`else
    chk("c5_residue", 8'(residue), 8'(6'b100000));
    chk("c5_aligned", 8'(aligned), 8'(0));
`endif

    // Count 0: immediate done, residue untouched.
    issue(0);
    drain(-1);
    chk("c0_residue", 8'(residue), 8'(oh(tot)));

    // Count 1 then count 6: both end aligned.
    issue(1);
    drain(-1);
    chk("c1_aligned", 8'(aligned), 8'(1));
    issue(6);
    drain(-1);
    chk("c6_aligned", 8'(aligned), 8'(1));

    // Back-to-back 3 then 4.
    issue(3);
    drain(4);
    drain(-1);
`ifdef DIV6_PAD_TO_SIX_EN
    chk("b2b_residue", 8'(residue), 8'(6'b000001));
`else
    chk("b2b_residue", 8'(residue), 8'(6'b000010));
`endif

    // Count 255 aborted by reset mid-SEND.
    issue(255);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      check_cycle(fin);
    end
    reset = 1'b1;
    #1;
    chk("abort_xy",      8'({x_out, y_out}), 8'(0));
    chk("abort_residue", 8'(residue),  8'(6'b000001));
    chk("abort_ref",     8'(ref_res),  8'(6'b000001));
    chk("abort_done",    8'(done),     8'(0));
    sb.delete();
    tot = 0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 8'(in_ready), 8'(1));
    chk("post_rst_busy",  8'(busy),     8'(0));

    // Full count 255.
    issue(255);
    drain(-1);
`ifdef DIV6_PAD_TO_SIX_EN
    chk("c255_residue", 8'(residue), 8'(6'b000001));
`else
    chk("c255_residue", 8'(residue), 8'(6'b001000));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
